// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_stall_ctrl : PC / IF-ID / ID-EX / EX sequencing for load-use, mul-div,
// branch flush and halt drain.  Macro HAZ_STALL_COUNT_EN builds stall counter.
// Revision: 1.0
// ============================================================================
module hazard_stall_ctrl #(
   parameter int MULDIV_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  id_opcode,
   input  logic [3:0]  id_rs,
   input  logic [3:0]  id_rt,
   input  logic [1:0]  ex_memRead,
   input  logic [3:0]  ex_rd,
   input  logic        ex_muldiv,
   input  logic        ex_branch_taken,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        ex_hold,
   output logic        halted,
   output logic [15:0] stall_count
);

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_MULDIV     = 2'd1;
   localparam logic [1:0] ST_HALT_DRAIN = 2'd2;
   localparam logic [1:0] ST_HALTED     = 2'd3;

   localparam logic       MD_EN   = (MULDIV_CYCLES > 1);
   localparam logic [3:0] MD_LOAD = (MULDIV_CYCLES > 1) ? 4'(MULDIV_CYCLES - 2) : 4'd0;

   logic [1:0] state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       load_use;
   logic       halt_op;

   assign load_use = (ex_memRead != 2'b00) && ((ex_rd == id_rs) || (ex_rd == id_rt));
   assign halt_op  = (id_opcode == 4'b0000);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_RUN: begin
            // A taken branch flushes ID, so nothing decoded there may start a sequence.
            if (!ex_branch_taken) begin
               if (ex_muldiv && MD_EN) begin
                  state_nxt = ST_MULDIV;
                  cnt_nxt   = MD_LOAD;
               end else if (!load_use && halt_op) begin
                  state_nxt = ST_HALT_DRAIN;
                  cnt_nxt   = 4'd2;
               end
            end
         end
         ST_MULDIV: begin
            if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            else             state_nxt = ST_RUN;
         end
         ST_HALT_DRAIN: begin
            if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            if (cnt <= 4'd1) state_nxt = ST_HALTED;
         end
         default: begin
            state_nxt = ST_HALTED;
         end
      endcase
   end

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      ex_hold     = 1'b0;
      halted      = 1'b0;
      case (state)
         ST_RUN: begin
            if (ex_branch_taken) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (ex_muldiv && MD_EN) begin
               ex_hold    = 1'b1;
               pc_write   = 1'b0;
               ifid_write = 1'b0;
            end else if (load_use || halt_op) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end
         end
         ST_MULDIV: begin
            if (cnt != 4'd0) begin
               ex_hold    = 1'b1;
               pc_write   = 1'b0;
               ifid_write = 1'b0;
            end
         end
         ST_HALT_DRAIN: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
         default: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            halted      = 1'b1;
         end
      endcase
   end

`ifdef HAZ_STALL_COUNT_EN
   logic [15:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt <= 16'd0;
      else if (!pc_write && (state != ST_HALTED) && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end

   assign stall_count = stall_cnt;
`else
   assign stall_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_stall_ctrl : directed vectors with a scoreboard queue and monitor.
// Revision: 1.0
// ============================================================================
module tb_hazard_stall_ctrl;

   // Expected strobe vector: {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, halted}
   localparam logic [5:0] DEF = 6'b110000;
   localparam logic [5:0] LU  = 6'b000100;
   localparam logic [5:0] BR  = 6'b111100;
   localparam logic [5:0] MD  = 6'b000010;
   localparam logic [5:0] HD  = 6'b000100;
   localparam logic [5:0] HLT = 6'b000101;

   typedef struct {
      string       name;
      logic [5:0]  exp;
      logic [15:0] sc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  id_opcode, id_rs, id_rt, ex_rd;
   logic [1:0]  ex_memRead;
   logic        ex_muldiv, ex_branch_taken;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, halted;
   logic [15:0] stall_count;

   logic        pc_write1, ifid_write1, ifid_flush1, idex_bubble1, ex_hold1, halted1;
   logic [15:0] stall_count1;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MULDIV_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .ex_memRead(ex_memRead), .ex_rd(ex_rd), .ex_muldiv(ex_muldiv),
      .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .ex_hold(ex_hold),
      .halted(halted), .stall_count(stall_count)
   );

   // Single-cycle mul/div build shares ex_muldiv; everything else idle.
   hazard_stall_ctrl #(.MULDIV_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_opcode(4'h1), .id_rs(4'h1), .id_rt(4'h2),
      .ex_memRead(2'b00), .ex_rd(4'h0), .ex_muldiv(ex_muldiv),
      .ex_branch_taken(1'b0), .pc_write(pc_write1), .ifid_write(ifid_write1),
      .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1), .ex_hold(ex_hold1),
      .halted(halted1), .stall_count(stall_count1)
   );

   task automatic step(input bit chk, input string nm, input logic rn,
                       input logic [3:0] opc, rs, rt, input logic [1:0] mr,
                       input logic [3:0] rd, input logic md, br,
                       input logic [5:0] ex, input logic [15:0] sc);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n           = rn;
      id_opcode       = opc;
      id_rs           = rs;
      id_rt           = rt;
      ex_memRead      = mr;
      ex_rd           = rd;
      ex_muldiv       = md;
      ex_branch_taken = br;
      if (chk) begin
         e.name = nm;
         e.exp  = ex;
`ifdef HAZ_STALL_COUNT_EN
         e.sc   = sc;
`else
         e.sc   = 16'd0;
`endif
         q.push_back(e);
      end
   endtask

   task automatic idle(input bit chk, input string nm, input logic rn,
                       input logic [5:0] ex, input logic [15:0] sc);
      step(chk, nm, rn, 4'h1, 4'h1, 4'h2, 2'b00, 4'h0, 1'b0, 1'b0, ex, sc);
   endtask

   // Monitor: every cycle carrying an expectation is compared mid-cycle.
   initial begin
      exp_t       e;
      logic [5:0] act;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e   = q.pop_front();
            act = {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, halted};
            n_checks++;
            if (act !== e.exp) begin
               n_fail++;
               $display("FAIL %s strobes: got %b required %b", e.name, act, e.exp);
            end
            n_checks++;
            if (stall_count !== e.sc) begin
               n_fail++;
               $display("FAIL %s stall_count: got %0d required %0d", e.name, stall_count, e.sc);
            end
            n_checks++;
            if ({pc_write1, ex_hold1, stall_count1} !== {1'b1, 1'b0, 16'd0}) begin
               n_fail++;
               $display("FAIL %s md1: got pc_write=%b ex_hold=%b sc=%0d required 1 0 0",
                        e.name, pc_write1, ex_hold1, stall_count1);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; id_opcode = 4'h1; id_rs = 4'h1; id_rt = 4'h2;
      ex_memRead = 2'b00; ex_rd = 4'h0; ex_muldiv = 1'b0; ex_branch_taken = 1'b0;

      idle(0, "rst", 1'b0, DEF, 0);
      idle(0, "rst", 1'b0, DEF, 0);
      idle(1, "reset_idle", 1'b1, DEF, 0);

      // Load-use on rs, then on rt with a byte load, then a non-matching load
      step(1, "lu_rs",    1, 4'h1, 4'h3, 4'h2, 2'b01, 4'h3, 0, 0, LU, 0);
      idle(1, "lu_after", 1, DEF, 1);
      step(1, "lu_rt",    1, 4'h1, 4'h1, 4'h5, 2'b10, 4'h5, 0, 0, LU, 1);
      step(1, "lu_nomatch", 1, 4'h1, 4'h1, 4'h2, 2'b01, 4'h7, 0, 0, DEF, 2);
      step(1, "nolu_noload", 1, 4'h1, 4'h7, 4'h2, 2'b00, 4'h7, 0, 0, DEF, 2);

      // Mul/div held 4 cycles; halt opcode in ID during the hold is ignored
      step(1, "md_c1", 1, 4'h1, 4'h1, 4'h2, 2'b00, 4'h0, 1, 0, MD, 2);
      step(1, "md_c2", 1, 4'h0, 4'h1, 4'h2, 2'b00, 4'h0, 1, 0, MD, 3);
      step(1, "md_c3", 1, 4'h0, 4'h3, 4'h2, 2'b01, 4'h3, 1, 0, MD, 4);
      step(1, "md_c4", 1, 4'h1, 4'h1, 4'h2, 2'b00, 4'h0, 1, 0, DEF, 5);
      idle(1, "md_after", 1, DEF, 5);

      // Branch beats halt, load-use and mul/div
      step(1, "br_halt", 1, 4'h0, 4'h3, 4'h2, 2'b01, 4'h3, 0, 1, BR, 5);
      idle(1, "br_after", 1, DEF, 5);
      step(1, "br_md",   1, 4'h1, 4'h1, 4'h2, 2'b00, 4'h0, 1, 1, BR, 5);
      idle(1, "br_md_after", 1, DEF, 5);

      // Halt drain: 3 bubble cycles then halted
      step(1, "halt_c0", 1, 4'h0, 4'h1, 4'h2, 2'b00, 4'h0, 0, 0, HD, 5);
      step(1, "halt_c1", 1, 4'h5, 4'h1, 4'h2, 2'b00, 4'h0, 0, 1, HD, 6);
      step(1, "halt_c2", 1, 4'h1, 4'h1, 4'h2, 2'b00, 4'h0, 1, 0, HD, 7);
      for (int i = 0; i < 20; i++)
         step(1, "halted_hold", 1, 4'(i), 4'(i), 4'(i + 1), 2'(i), 4'(i),
              1'(i), 1'(i >> 1), HLT, 8);

      // Reset out of HALTED
      idle(1, "rst_in_halted", 1'b0, HLT, 8);
      idle(1, "post_rst_halted", 1'b1, DEF, 0);

      // Reset in MULDIV with cnt=1
      step(1, "md2_c1", 1, 4'h1, 4'h1, 4'h2, 2'b00, 4'h0, 1, 0, MD, 0);
      step(1, "md2_c2", 1, 4'h1, 4'h1, 4'h2, 2'b00, 4'h0, 1, 0, MD, 1);
      step(1, "rst_in_md", 0, 4'h1, 4'h1, 4'h2, 2'b00, 4'h0, 1, 0, MD, 2);
      idle(1, "post_rst_md", 1'b1, DEF, 0);
      idle(1, "post_rst_md2", 1'b1, DEF, 0);

      @(posedge clk);
      @(posedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
